sub16_nibble_serial: RTL and testbench
======================================

Name: sub16_nibble_serial

Overview:
Sequential 16-bit subtractor, the inverse operation to the team's 16-bit ripple adder chain.
- Computes D = A - B one 4-bit slice per cycle, LSB nibble first, with a registered borrow between slices.
- Trades latency for area: one 4-bit subtract cell is reused over 4 cycles.
- Valid/ready handshake on both input and output; sits beside the adder in the datapath ALU.

Parameters:
NIBBLES, 4, number of 4-bit slices; fixed at 4 for 16-bit operands
NIB_W, 4, slice width in bits

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands A/B valid
in_ready  output  1  block can accept operands
A  input  16  minuend
B  input  16  subtrahend
out_valid  output  1  result D/Bout/Ovfl valid
out_ready  input  1  consumer accepts result
D  output  16  difference A - B, modulo 2^16
Bout  output  1  unsigned borrow; 1 iff A < B unsigned
Ovfl  output  1  signed (two's complement) overflow

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge) forces state IDLE and clears all of: D=0, Bout=0, Ovfl=0, out_valid=0, nibble index=0, borrow register=0. in_ready=1 after reset.
- Reset mid-operation (CALC or DONE) abandons the operation and yields the same result; no partial result is ever presented.
- State machine: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch A and B into internal registers; idx=0; carry register=1 (A + ~B + 1 form); go to CALC.
- CALC:
  - in_ready=0; A/B input changes are ignored.
  - Each cycle: slice = A_r[idx] + ~B_r[idx] + carry; write the 4-bit sum into D_r[idx]; carry <= slice carry-out; idx++.
  - After idx=3, go to DONE.
- DONE:
  - out_valid=1.
  - Bout = ~final carry.
  - Ovfl = (A_r[15] != B_r[15]) && (D_r[15] != A_r[15]).
  - D/Bout/Ovfl are held stable while out_ready=0.
  - On out_ready=1, go to IDLE; out_valid drops next cycle.
- Latency: accept edge at cycle 0; slices computed on edges 1-4; out_valid high from cycle 4 onward. Minimum 5 cycles per operation; no overlap.
- Back-to-back: in_ready rises only in the cycle after the output handshake, so accept and output never happen in the same cycle.
- Width rules: D wraps modulo 2^16. Bout and Ovfl are independent flags.
- Registers: D, out_valid and in_ready are driven from registers or state decode only; there is no combinational path from inputs to outputs.
- in_valid while busy: ignored; the upstream holds it until in_ready.

Optional Feature:
SUB16_SAT_EN
- Defined: when Ovfl=1 in DONE, D is replaced by the signed saturated value: 0x7FFF if A_r[15]=0, else 0x8000. Bout and Ovfl are still reported unmodified.
- Undefined: D is always the wrapped result; no saturation logic is synthesized.

Decomposition:
- Shared package sub16_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - constants WIDTH=16, NIB_W=4, NIBBLES=4;
  - SAT_POS=16'h7FFF, SAT_NEG=16'h8000.
- One sub-module, sub_nibble4: combinational 4-bit A + ~B + cin producing a 4-bit sum and cout. It is instantiated once and reused each CALC cycle.

Test Plan:
- Basic: A=0x0005, B=0x0003 → D=0x0002, Bout=0, Ovfl=0; out_valid first high exactly 4 cycles after the accept edge.
- Unsigned borrow: A=0x0000, B=0x0001 → D=0xFFFF, Bout=1, Ovfl=0; the borrow ripples through all four slices.
- Signed overflow: A=0x8000, B=0x0001 → D=0x7FFF, Ovfl=1, Bout=0; with SUB16_SAT_EN → D=0x8000.
- Overflow positive: A=0x7FFF, B=0xFFFF → D=0x8000, Ovfl=1, Bout=1; with SUB16_SAT_EN → D=0x7FFF.
- Backpressure/back-to-back:
  - Hold out_ready=0 for 10 cycles: D stays stable and in_ready stays 0.
  - Release out_ready: in_ready=1 the next cycle; second op A=0x1234, B=0x0234 → D=0x1000.
- Reset mid-CALC: assert rst in CALC cycle 2 → next cycle out_valid=0, D=0, in_ready=1; a new op A=0x0010, B=0x0001 → D=0x000F.

Source files
------------

// File: rtl/sub16_pkg.sv
// Shared types and constants for the nibble-serial 16-bit subtractor.
package sub16_pkg;

    localparam int WIDTH   = 16;
    localparam int NIB_W   = 4;
    localparam int NIBBLES = 4;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two's complement overflow of A - B judged from the sign bits alone.
    function automatic logic signed_ovfl(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/sub_nibble4.sv
// One 4-bit subtract slice in A + ~B + cin form; cout=1 means no borrow out.
import sub16_pkg::*;

module sub_nibble4 (
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] w_total;

    assign w_total = {1'b0, a} + {1'b0, ~b} + {{NIB_W{1'b0}}, cin};
    assign sum     = w_total[NIB_W-1:0];
    assign cout    = w_total[NIB_W];

endmodule

// File: rtl/sub16_nibble_serial.sv
// Sequential 16-bit subtractor, one nibble per cycle with a registered borrow chain.
// Build option SUB16_SAT_EN saturates D to the signed limit when Ovfl is set.
import sub16_pkg::*;

module sub16_nibble_serial (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  D,
    output logic              Bout,
    output logic              Ovfl
);

    state_e             r_state;
    state_e             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [11:0]        r_acc;
    logic [1:0]         r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_d;
    logic               r_bout;
    logic               r_ovfl;
    logic               r_out_valid;

    logic               w_accept;
    logic [NIB_W-1:0]   w_a_nib;
    logic [NIB_W-1:0]   w_b_nib;
    logic [NIB_W-1:0]   w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_d_wrap;
    logic               w_ovfl;
    logic [WIDTH-1:0]   w_d_final;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_a_nib  = r_a[{r_idx, 2'b00} +: NIB_W];
    assign w_b_nib  = r_b[{r_idx, 2'b00} +: NIB_W];

    sub_nibble4 u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Final slice lands straight in the output register, so D never shows a partial value.
    assign w_d_wrap = {w_sum, r_acc};
    assign w_ovfl   = signed_ovfl(r_a[15], r_b[15], w_sum[NIB_W-1]);

    // Result selection: wrapped difference, or signed saturation when enabled.
    always_comb begin
        w_d_final = w_d_wrap;
`ifdef SUB16_SAT_EN
        if (w_ovfl) begin
            if (r_a[15]) begin
                w_d_final = SAT_NEG;
            end else begin
                w_d_final = SAT_POS;
            end
        end else begin
            w_d_final = w_d_wrap;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = CALC;
                else          w_state_next = IDLE;
            end
            CALC: begin
                if (r_idx == 2'd3) w_state_next = DONE;
                else               w_state_next = CALC;
            end
            DONE: begin
                if (out_ready) w_state_next = IDLE;
                else           w_state_next = DONE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, per-slice accumulation and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= 16'h0000;
            r_b         <= 16'h0000;
            r_acc       <= 12'h000;
            r_idx       <= 2'd0;
            r_carry     <= 1'b0;
            r_d         <= 16'h0000;
            r_bout      <= 1'b0;
            r_ovfl      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_idx   <= 2'd0;
                        r_carry <= 1'b1;
                    end
                end
                CALC: begin
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 2'd1;
                    case (r_idx)
                        2'd0:    r_acc[3:0]  <= w_sum;
                        2'd1:    r_acc[7:4]  <= w_sum;
                        2'd2:    r_acc[11:8] <= w_sum;
                        default: begin
                            r_d         <= w_d_final;
                            r_bout      <= ~w_cout;
                            r_ovfl      <= w_ovfl;
                            r_out_valid <= 1'b1;
                        end
                    endcase
                end
                DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign D         = r_d;
    assign Bout      = r_bout;
    assign Ovfl      = r_ovfl;

endmodule

// File: tb/tb_sub16_nibble_serial.sv
// Directed, table-driven bench for sub16_nibble_serial (wrap or saturating build).
module tb_sub16_nibble_serial;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] D;
    logic        Bout;
    logic        Ovfl;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d_wrap;
        logic [15:0] d_sat;
        logic        bout;
        logic        ovfl;
    } vec_t;

    vec_t vecs [9];

    sub16_nibble_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .Ovfl      (Ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold_cycles of backpressure before the output handshake.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold_cycles,
                         output logic [15:0] d, output logic bo, output logic ov);
        int waited;
        int lat;
        logic [15:0] d_first;
        waited = 0;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles", waited);
        end
        in_valid = 1'b1;
        A = a;
        B = b;
        step();
        // Upstream keeps in_valid up with junk operands; they must be ignored while busy.
        A = ~a;
        B = a ^ b;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("latency", lat, 4);
        d_first = D;
        for (int i = 0; i < hold_cycles; i++) begin
            step();
            check("hold_d_stable", D, d_first);
            check("hold_in_ready", in_ready, 1'b0);
        end
        d  = D;
        bo = Bout;
        ov = Ovfl;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_hs_out_valid", out_valid, 1'b0);
        check("post_hs_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic [15:0] exp_d;

        vecs[0] = '{16'h0005, 16'h0003, 16'h0002, 16'h0002, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'hABCD, 16'h1234, 16'h9999, 16'h9999, 1'b0, 1'b0};
        vecs[8] = '{16'h00F0, 16'h000F, 16'h00E1, 16'h00E1, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 16'h0000;
        B         = 16'h0000;
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_d", D, 16'h0000);
        check("rst_bout", Bout, 1'b0);
        check("rst_ovfl", Ovfl, 1'b0);

        for (int i = 0; i < 9; i++) begin
`ifdef SUB16_SAT_EN
            exp_d = vecs[i].d_sat;
`else
            exp_d = vecs[i].d_wrap;
`endif
            do_op(vecs[i].a, vecs[i].b, i % 3, d, bo, ov);
            check($sformatf("vec%0d_d", i), d, exp_d);
            check($sformatf("vec%0d_bout", i), bo, vecs[i].bout);
            check($sformatf("vec%0d_ovfl", i), ov, vecs[i].ovfl);
        end

        // Long backpressure, then an immediate second operation.
        do_op(16'h0005, 16'h0003, 10, d, bo, ov);
        check("bp_d", d, 16'h0002);
        do_op(16'h1234, 16'h0234, 0, d, bo, ov);
        check("b2b_d", d, 16'h1000);
        check("b2b_bout", bo, 1'b0);

        // Reset during the second CALC cycle abandons the operation.
        in_valid = 1'b1;
        A = 16'hFFFF;
        B = 16'h0001;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_d", D, 16'h0000);
        check("midrst_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst_no_result", out_valid, 1'b0);
        end
        do_op(16'h0010, 16'h0001, 1, d, bo, ov);
        check("midrst_new_d", d, 16'h000F);
        check("midrst_new_bout", bo, 1'b0);
        check("midrst_new_ovfl", ov, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
